wave_generator: RTL and testbench

Parametrised multi-mode audio oscillator, successor to the fixed 16-bit triangle source. A phase accumulator with a programmable increment drives triangle, square or sawtooth shaping, followed by amplitude scaling. Samples advance only on the audio sample strobe. A graceful stop finishes the current period so the tone ends on an exact zero instead of clicking. Output feeds the audio mixer/DAC path as a signed sample stream with a valid strobe.

---
 rtl/wave_generator.sv | 160 ++++++++++++++++
 tb/tb_wave_generator.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wave_generator.sv
// Multi-mode audio oscillator: phase accumulator feeding triangle/square/saw
// shaping and amplitude scaling, with a graceful stop that ends on a zero sample.
module wave_generator #(
    parameter int DATA_W  = 16,
    parameter int PHASE_W = 24,    // must be >= DATA_W+1
    parameter int AMP_W   = 9      // must be >= 9 so unity (256) is representable
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_start,
    input  logic                      i_stop,
    input  logic                      i_sample_en,
    input  logic [1:0]                i_mode,
    input  logic [PHASE_W-1:0]        i_phase_inc,
    input  logic [AMP_W-1:0]          i_amp,
    output logic signed [DATA_W-1:0]  o_data,
    output logic                      o_valid,
    output logic                      o_busy
);

    // state | meaning
    // IDLE  | silent, strobes ignored, phase parked
    // RUN   | oscillating, one sample per strobe
    // DRAIN | oscillating until the phase wraps; wrap sample forced to zero
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [DATA_W-1:0]  SIGN_BIT = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0]  SQ_POS   = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0]  SQ_NEG   = {1'b1, {(DATA_W-2){1'b0}}, 1'b1};
    localparam logic [PHASE_W-1:0] QUARTER  = {2'b01, {(PHASE_W-2){1'b0}}};
    localparam logic [8:0]         UNITY    = 9'd256;

    state_t state, state_nxt;

    logic [PHASE_W-1:0] phase;
    logic [PHASE_W:0]   phase_sum;
    logic               wrap;

    logic               strobe_act;
    logic               restart;
    logic               hard_stop;
    logic               force_zero;

    logic [PHASE_W-1:0] tri_q;
    logic [DATA_W-1:0]  tri_x;
    logic [DATA_W-1:0]  tri_v;
    logic [DATA_W-1:0]  saw_v;
    logic [DATA_W-1:0]  raw_nxt;
    logic [8:0]         amp_clamp;

    logic                      valid_s1;
    logic                      force_s1;
    logic signed [DATA_W-1:0]  raw_s1;
    logic [8:0]                amp_s1;
    logic signed [DATA_W+9:0]  prod;
    logic signed [DATA_W-1:0]  scaled;

    // FSM: state register
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM: next state (stop outranks start outside IDLE)
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (i_start) state_nxt = RUN;
            end
            RUN: begin
                if (i_stop) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (i_stop)                    state_nxt = IDLE;
                else if (i_start)              state_nxt = RUN;
                else if (strobe_act && wrap)   state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // FSM: decoded controls
    always_comb begin
        strobe_act = i_sample_en && (state != IDLE);
        restart    = i_start && ((state == IDLE) || !i_stop);
        hard_stop  = (state == DRAIN) && i_stop;
        force_zero = (state == DRAIN) && wrap && !i_start;
        // busy covers the sample still in stage 1 so it drops with the last o_valid
        o_busy     = (state != IDLE) || valid_s1;
    end

    assign phase_sum = {1'b0, phase} + {1'b0, i_phase_inc};
    assign wrap      = phase_sum[PHASE_W];

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            phase <= '0;
        end else if (restart) begin
            phase <= '0;
        end else if (strobe_act) begin
            phase <= phase_sum[PHASE_W-1:0];
        end
    end

    // Triangle is the quarter-shifted phase folded at half period, re-centred
    // by flipping the sign bit.
    always_comb begin
        tri_q = phase + QUARTER;
        tri_x = DATA_W'(tri_q >> (PHASE_W - 1 - DATA_W));
        tri_v = (tri_q[PHASE_W-1] ? ~tri_x : tri_x) ^ SIGN_BIT;
        saw_v = DATA_W'(phase >> (PHASE_W - DATA_W));
        case (i_mode)
            2'b00:   raw_nxt = tri_v;
            2'b01:   raw_nxt = phase[PHASE_W-1] ? SQ_NEG : SQ_POS;
            2'b10:   raw_nxt = saw_v;
            default: raw_nxt = '0;
        endcase
        amp_clamp = (i_amp > AMP_W'(256)) ? UNITY : i_amp[8:0];
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || hard_stop) begin
            valid_s1 <= 1'b0;
            force_s1 <= 1'b0;
            raw_s1   <= '0;
            amp_s1   <= '0;
        end else begin
            valid_s1 <= strobe_act;
            if (strobe_act) begin
                force_s1 <= force_zero;
                raw_s1   <= raw_nxt;
                amp_s1   <= amp_clamp;
            end
        end
    end

    // |raw| <= 2^(DATA_W-1) and gain <= 1, so the floored product always fits
    assign prod   = $signed({{10{raw_s1[DATA_W-1]}}, raw_s1})
                  * $signed({{(DATA_W+1){1'b0}}, amp_s1});
    assign scaled = DATA_W'(prod >>> 8);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || hard_stop) begin
            o_valid <= 1'b0;
            o_data  <= '0;
        end else begin
            o_valid <= valid_s1;
            o_data  <= (valid_s1 && !force_s1) ? scaled : '0;
        end
    end

endmodule

// File: tb/tb_wave_generator.sv
// Self-checking bench for wave_generator: an arithmetic reference model with a
// timestamped expectation queue, checked every cycle, plus literal sample pins.
module tb_wave_generator;

    localparam int     DATA_W    = 16;
    localparam int     PHASE_W   = 24;
    localparam int     AMP_W     = 9;
    localparam longint PHASE_MOD = longint'(1) << PHASE_W;
    localparam longint HALF_OUT  = longint'(1) << (DATA_W - 1);

    logic                      clk;
    logic                      i_rst_n;
    logic                      i_start;
    logic                      i_stop;
    logic                      i_sample_en;
    logic [1:0]                i_mode;
    logic [PHASE_W-1:0]        i_phase_inc;
    logic [AMP_W-1:0]          i_amp;
    logic signed [DATA_W-1:0]  o_data;
    logic                      o_valid;
    logic                      o_busy;

    wave_generator #(.DATA_W(DATA_W), .PHASE_W(PHASE_W), .AMP_W(AMP_W)) dut (
        .i_clk       (clk),
        .i_rst_n     (i_rst_n),
        .i_start     (i_start),
        .i_stop      (i_stop),
        .i_sample_en (i_sample_en),
        .i_mode      (i_mode),
        .i_phase_inc (i_phase_inc),
        .i_amp       (i_amp),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .o_busy      (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int     due;
        longint val;
    } exp_t;

    exp_t   exp_q[$];
    longint seen[$];
    int     seen_cyc[$];
    int     cyc           = 0;
    int     n_checks      = 0;
    int     n_fail        = 0;
    bit     chk_on        = 1'b0;
    int     m_state       = 0;   // 0 idle, 1 run, 2 drain
    longint m_phase       = 0;
    int     busy_fall_cyc = -1;
    int     s0;

    task automatic check(input string name, input longint act, input longint req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, req);
        end
    endtask

    function automatic longint raw_of(input int mode, input longint p);
        longint h, q, x;
        h = PHASE_MOD / 2;
        case (mode)
            0: begin
                q = (p + PHASE_MOD / 4) % PHASE_MOD;
                x = (q % h) >> (PHASE_W - 1 - DATA_W);
                if (q >= h) x = (2 * HALF_OUT - 1) - x;
                return x - HALF_OUT;
            end
            1: return (p >= h) ? -(HALF_OUT - 1) : (HALF_OUT - 1);
            2: begin
                x = p >> (PHASE_W - DATA_W);
                return (x >= HALF_OUT) ? x - 2 * HALF_OUT : x;
            end
            default: return 0;
        endcase
    endfunction

    function automatic longint scale(input longint raw, input longint amp);
        longint a, prod, m;
        a    = (amp > 256) ? 256 : amp;
        prod = raw * a;
        m    = prod % 256;
        if (m < 0) m += 256;
        return (prod - m) / 256;
    endfunction

    function automatic longint seen_at(input int k);
        return (seen.size() > k) ? seen[k] : -999999;
    endfunction

    task automatic clear_seen();
        seen.delete();
        seen_cyc.delete();
    endtask

    // One clock: drive inputs, advance the model for the coming edge, return
    // just after the following falling edge.
    task automatic step(input bit start, input bit stop, input bit en);
        longint v;
        bit     emit, wrap;
        i_start     = start;
        i_stop      = stop;
        i_sample_en = en;
        if (!i_rst_n) begin
            m_state = 0;
            m_phase = 0;
            exp_q.delete();
        end else begin
            emit = en && (m_state != 0);
            wrap = emit && (m_phase + longint'(i_phase_inc) >= PHASE_MOD);
            if (m_state == 2 && stop) begin
                exp_q.delete();
                m_state = 0;
            end else begin
                if (emit) begin
                    v = (m_state == 2 && wrap && !start) ? 0
                        : scale(raw_of(int'(i_mode), m_phase), longint'(i_amp));
                    exp_q.push_back('{due: cyc + 2, val: v});
                end
                if (start && (m_state == 0 || !stop)) begin
                    m_phase = 0;
                    m_state = 1;
                end else begin
                    if (emit) m_phase = (m_phase + longint'(i_phase_inc)) % PHASE_MOD;
                    if (m_state == 1 && stop)      m_state = 2;
                    else if (m_state == 2 && wrap) m_state = 0;
                end
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
        #1;
        i_start     = 1'b0;
        i_stop      = 1'b0;
        i_sample_en = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, 0);
    endtask

    task automatic strobes(input int n);
        repeat (n) step(0, 0, 1);
    endtask

    always @(negedge clk) begin : cmp
        exp_t e;
        bit   pend;
        if (chk_on) begin
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                e = exp_q.pop_front();
                check("valid", longint'(o_valid), 1);
                check("data", longint'(o_data), e.val);
            end else begin
                check("valid_quiet", longint'(o_valid), 0);
                if (m_state == 0 && exp_q.size() == 0)
                    check("data_idle", longint'(o_data), 0);
            end
            pend = 1'b0;
            foreach (exp_q[i]) if (exp_q[i].due > cyc) pend = 1'b1;
            check("busy", longint'(o_busy), longint'(m_state != 0 || pend));
        end
    end

    always @(negedge clk) begin
        if (chk_on && o_valid) begin
            seen.push_back(longint'(o_data));
            seen_cyc.push_back(cyc);
            if (!o_busy && busy_fall_cyc < 0) busy_fall_cyc = cyc;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        i_rst_n     = 1'b0;
        i_start     = 1'b0;
        i_stop      = 1'b0;
        i_sample_en = 1'b0;
        i_mode      = 2'b00;
        i_phase_inc = '0;
        i_amp       = '0;

        check("pin_tri_quarter", raw_of(0, 64'h400000), 32767);
        check("pin_tri_eighth", raw_of(0, 64'h200000), 16384);
        check("pin_saw_half", raw_of(2, 64'h800000), -32768);
        check("pin_sq_scale", scale(raw_of(1, 64'h800000), 128), -16384);

        // reset
        step(0, 0, 0);
        chk_on = 1'b1;
        step(0, 0, 0);
        check("rst_data", longint'(o_data), 0);
        check("rst_valid", longint'(o_valid), 0);
        check("rst_busy", longint'(o_busy), 0);
        i_rst_n = 1'b1;
        strobes(2);
        check("idle_strobe_ignored", longint'(seen.size()), 0);

        // sawtooth at unity gain
        i_mode = 2'b10; i_phase_inc = 24'h010000; i_amp = 9'd256;
        step(1, 0, 0);
        check("busy_after_start", longint'(o_busy), 1);
        clear_seen();
        s0 = cyc;
        strobes(257);
        idle(3);
        check("saw_count", longint'(seen.size()), 257);
        check("saw_latency", longint'(seen_cyc.size() > 0 ? seen_cyc[0] - s0 : -1), 2);
        check("saw_0", seen_at(0), 0);
        check("saw_1", seen_at(1), 256);
        check("saw_127", seen_at(127), 32512);
        check("saw_128", seen_at(128), -32768);
        check("saw_255", seen_at(255), -256);
        check("saw_256", seen_at(256), 0);
        step(0, 1, 0);
        step(0, 1, 0);

        // triangle, then restart while running
        i_mode = 2'b00; i_phase_inc = 24'h040000;
        step(1, 0, 0);
        clear_seen();
        strobes(65);
        idle(3);
        check("tri_0", seen_at(0), 0);
        check("tri_1", seen_at(1), 2048);
        check("tri_16", seen_at(16), 32767);
        check("tri_32", seen_at(32), -1);
        check("tri_48", seen_at(48), -32768);
        check("tri_64", seen_at(64), 0);
        clear_seen();
        step(0, 0, 1);
        step(1, 0, 0);
        step(0, 0, 1);
        idle(3);
        check("restart_inflight", seen_at(0), 2048);
        check("restart_zero", seen_at(1), 0);

        // square with half gain, clamped gain, reserved mode
        i_mode = 2'b01; i_phase_inc = 24'h100000; i_amp = 9'd128;
        step(1, 0, 0);
        idle(1);
        clear_seen();
        strobes(16);
        idle(3);
        check("sq_0", seen_at(0), 16383);
        check("sq_7", seen_at(7), 16383);
        check("sq_8", seen_at(8), -16384);
        check("sq_15", seen_at(15), -16384);
        i_amp = 9'd300;
        clear_seen();
        strobes(16);
        idle(3);
        check("sq_clamp_pos", seen_at(0), 32767);
        check("sq_clamp_neg", seen_at(8), -32767);
        i_mode = 2'b11;
        clear_seen();
        strobes(4);
        idle(3);
        check("mode3_count", longint'(seen.size()), 4);
        check("mode3_val", seen_at(2), 0);
        step(0, 1, 0);
        step(0, 1, 0);

        // graceful stop
        i_mode = 2'b10; i_phase_inc = 24'h100000; i_amp = 9'd256;
        step(1, 0, 0);
        clear_seen();
        busy_fall_cyc = -1;
        for (int n = 0; n < 20; n++) begin
            step(0, 0, 1);
            if (n == 5) step(0, 1, 0); else step(0, 0, 0);
            idle(2);
        end
        check("drain_count", longint'(seen.size()), 16);
        check("drain_6", seen_at(6), 24576);
        check("drain_14", seen_at(14), -8192);
        check("drain_final_zero", seen_at(15), 0);
        check("drain_busy_fall", longint'(busy_fall_cyc),
              longint'(seen_cyc.size() > 15 ? seen_cyc[15] : -2));
        check("drain_busy_low", longint'(o_busy), 0);

        // priority, restart from drain, hard stop
        step(1, 0, 0);
        strobes(3);
        step(1, 1, 1);
        idle(2);
        check("startstop_drain_busy", longint'(o_busy), 1);
        clear_seen();
        step(0, 0, 1);
        step(1, 0, 0);
        step(0, 0, 1);
        idle(3);
        check("stop_wins_no_reset", seen_at(0), 16384);
        check("drain_restart_zero", seen_at(1), 0);
        step(0, 1, 0);
        step(0, 0, 1);
        step(0, 1, 0);
        check("hard_valid", longint'(o_valid), 0);
        check("hard_data", longint'(o_data), 0);
        check("hard_busy", longint'(o_busy), 0);
        idle(3);
        check("hard_dropped", longint'(seen.size()), 2);

        // reset mid-run
        step(1, 0, 0);
        strobes(3);
        i_rst_n = 1'b0;
        step(0, 0, 1);
        check("midrst_data", longint'(o_data), 0);
        check("midrst_valid", longint'(o_valid), 0);
        check("midrst_busy", longint'(o_busy), 0);
        i_rst_n = 1'b1;
        clear_seen();
        strobes(4);
        idle(2);
        check("midrst_ignored", longint'(seen.size()), 0);
        step(1, 0, 0);
        step(0, 0, 1);
        idle(3);
        check("midrst_restart_count", longint'(seen.size()), 1);
        check("midrst_restart_zero", seen_at(0), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
